// File: rtl/oled_pkg.sv
// Shared constants for the OLED SPI receiver: addressing modes, command codes
// and the command-decoder state encoding.
package oled_pkg;

    localparam logic [1:0] MODE_HORIZ = 2'b00;
    localparam logic [1:0] MODE_PAGE  = 2'b10;

    localparam logic [7:0] CMD_SET_MODE  = 8'h20;
    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;

    typedef enum logic {
        S_CMD  = 1'b0,
        S_MODE = 1'b1
    } cmd_state_t;

    // Only horizontal and page addressing are modelled; vertical/reserved are ignored.
    function automatic logic mode_supported(input logic [1:0] mode);
        return (mode == MODE_HORIZ) || (mode == MODE_PAGE);
    endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// Synchroniser, sclk rising-edge detector and 8-bit MSB-first deserialiser.
// With OLED_SPI_CS_EN defined, oled_cs_n gates edges and frames partial bytes.
module spi_rx_shift
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       oled_sclk,
    input  logic       oled_mosi,
    input  logic       oled_dc,
`ifdef OLED_SPI_CS_EN
    input  logic       oled_cs_n,
`endif
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       byte_err
);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] dc_sync_r;
    logic                   sclk_prev_r;
    logic [7:0]             shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   dc_s;
    logic                   cs_high_s;
    logic                   cs_rise_s;
    logic                   rise_s;

    // Input synchronisers and previous-sclk flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            dc_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], oled_sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], oled_mosi};
            dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], oled_dc};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    assign dc_s   = dc_sync_r[SYNC_STAGES-1];

`ifdef OLED_SPI_CS_EN
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   cs_prev_r;
    logic                   byte_err_r;

    // Chip-select synchroniser and its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_r <= {SYNC_STAGES{1'b0}};
            cs_prev_r <= 1'b0;
        end else begin
            cs_sync_r <= {cs_sync_r[SYNC_STAGES-2:0], oled_cs_n};
            cs_prev_r <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign cs_high_s = cs_sync_r[SYNC_STAGES-1];
    assign cs_rise_s = cs_high_s & ~cs_prev_r;

    // Sticky flag for a byte abandoned by deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_err_r <= 1'b0;
        end else if (cs_rise_s && (bit_cnt_r != 3'd0)) begin
            byte_err_r <= 1'b1;
        end
    end

    assign byte_err = byte_err_r;
`else
    assign cs_high_s = 1'b0;
    assign cs_rise_s = 1'b0;
    assign byte_err  = 1'b0;
`endif

    assign rise_s = sclk_s & ~sclk_prev_r & ~cs_high_s;

    // Deserialiser: shift on each accepted edge, drop partial byte on deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else if (cs_rise_s) begin
            bit_cnt_r <= 3'd0;
        end else if (rise_s) begin
            shift_r   <= {shift_r[6:0], mosi_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    // The completing edge is reported combinationally; the top registers it.
    assign byte_valid = rise_s & (bit_cnt_r == 3'd7);
    assign rx_byte    = {shift_r[6:0], mosi_s};
    assign rx_dc      = dc_s;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED link device end: command decoder plus page/column addressing into a
// COLS x PAGES shadow frame buffer. Optional chip select via OLED_SPI_CS_EN.
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              oled_sclk,
    input  logic              oled_mosi,
    input  logic              oled_dc,
`ifdef OLED_SPI_CS_EN
    input  logic              oled_cs_n,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              byte_err
);

    localparam int COL_W  = $clog2(COLS);
    localparam int PAGE_W = $clog2(PAGES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    logic              byte_valid_s;
    logic [7:0]        rx_byte_s;
    logic              rx_dc_s;

    cmd_state_t        state_r, state_s;
    logic [PAGE_W-1:0] page_r, page_s;
    logic [COL_W-1:0]  col_r, col_s;
    logic [1:0]        mode_r, mode_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [7:0]        wr_data_s;
    logic              cmd_valid_s;
    logic [7:0]        cmd_byte_s;

    spi_rx_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .oled_sclk  (oled_sclk),
        .oled_mosi  (oled_mosi),
        .oled_dc    (oled_dc),
`ifdef OLED_SPI_CS_EN
        .oled_cs_n  (oled_cs_n),
`endif
        .byte_valid (byte_valid_s),
        .rx_byte    (rx_byte_s),
        .rx_dc      (rx_dc_s),
        .byte_err   (byte_err)
    );

    // Command decode, address advance and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        page_s      = page_r;
        col_s       = col_r;
        mode_s      = mode_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr;
        wr_data_s   = wr_data;
        cmd_valid_s = 1'b0;
        cmd_byte_s  = cmd_byte;
        if (byte_valid_s) begin
            if (rx_dc_s) begin
                wr_en_s   = 1'b1;
                wr_addr_s = ADDR_W'(page_r) * ADDR_W'(COLS) + ADDR_W'(col_r);
                wr_data_s = rx_byte_s;
                if (col_r == COL_LAST) begin
                    col_s = {COL_W{1'b0}};
                    if (mode_r == MODE_HORIZ) begin
                        if (page_r == PAGE_LAST) begin
                            page_s = {PAGE_W{1'b0}};
                        end else begin
                            page_s = page_r + PAGE_W'(1);
                        end
                    end else begin
                        page_s = page_r;
                    end
                end else begin
                    col_s = col_r + COL_W'(1);
                end
            end else begin
                cmd_valid_s = 1'b1;
                cmd_byte_s  = rx_byte_s;
                case (state_r)
                    S_CMD: begin
                        if (rx_byte_s[7:4] == CMD_COL_LO[7:4]) begin
                            col_s[3:0] = rx_byte_s[3:0];
                        end else if (rx_byte_s[7:4] == CMD_COL_HI[7:4]) begin
                            col_s[6:4] = rx_byte_s[2:0];
                        end else if (rx_byte_s[7:3] == CMD_PAGE_BASE[7:3]) begin
                            page_s = rx_byte_s[PAGE_W-1:0];
                        end else if (rx_byte_s == CMD_SET_MODE) begin
                            state_s = S_MODE;
                        end else begin
                            state_s = S_CMD;
                        end
                    end
                    S_MODE: begin
                        if (mode_supported(rx_byte_s[1:0])) begin
                            mode_s = rx_byte_s[1:0];
                        end else begin
                            mode_s = mode_r;
                        end
                        state_s = S_CMD;
                    end
                    default: begin
                        state_s = S_CMD;
                    end
                endcase
            end
        end else begin
            wr_en_s     = 1'b0;
            cmd_valid_s = 1'b0;
        end
    end

    // Decoder state, address counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_CMD;
            page_r    <= {PAGE_W{1'b0}};
            col_r     <= {COL_W{1'b0}};
            mode_r    <= MODE_PAGE;
            wr_en     <= 1'b0;
            wr_addr   <= {ADDR_W{1'b0}};
            wr_data   <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
        end else begin
            state_r   <= state_s;
            page_r    <= page_s;
            col_r     <= col_s;
            mode_r    <= mode_s;
            wr_en     <= wr_en_s;
            wr_addr   <= wr_addr_s;
            wr_data   <= wr_data_s;
            cmd_valid <= cmd_valid_s;
            cmd_byte  <= cmd_byte_s;
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: directed addressing scenarios plus a
// randomized byte stream checked against an arithmetic frame-buffer model.
module tb_oled_spi_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       oled_sclk = 1'b0;
    logic       oled_mosi = 1'b0;
    logic       oled_dc = 1'b0;
`ifdef OLED_SPI_CS_EN
    logic       oled_cs_n = 1'b0;
`endif
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       byte_err;

    oled_spi_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .oled_sclk (oled_sclk),
        .oled_mosi (oled_mosi),
        .oled_dc   (oled_dc),
`ifdef OLED_SPI_CS_EN
        .oled_cs_n (oled_cs_n),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .byte_err  (byte_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_data;
        logic [7:0] b;
        int         addr;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  chk_on = 1'b0;
    int  last_addr = -1;
    int  last_data = -1;

    // Model of the display controller's addressing state.
    int  m_page = 0;
    int  m_col = 0;
    bit  m_horiz = 1'b0;
    bit  m_pend = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_page = 0; m_col = 0; m_horiz = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit d, output int addr);
        int v;
        v = int'(b);
        addr = -1;
        if (d) begin
            addr = m_page * 128 + m_col;
            m_col = m_col + 1;
            if (m_col == 128) begin
                m_col = 0;
                if (m_horiz) m_page = (m_page + 1) % 8;
            end
        end else if (m_pend) begin
            if (v % 4 == 0) m_horiz = 1'b1;
            else if (v % 4 == 2) m_horiz = 1'b0;
            m_pend = 1'b0;
        end else if (v < 16) begin
            m_col = (m_col / 16) * 16 + v % 16;
        end else if (v < 32 && v != 32) begin
            m_col = m_col % 16 + (v % 8) * 16;
        end else if (v >= 176 && v <= 183) begin
            m_page = v - 176;
        end else if (v == 32) begin
            m_pend = 1'b1;
        end
    endtask

    // One SPI bit: low phase with data set up, then rising edge and high phase.
    task automatic send_bit(input logic b, input logic d, input bit last,
                            input logic [7:0] whole, output int addr);
        ev_t ev;
        oled_sclk = 1'b0; oled_mosi = b; oled_dc = d;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        oled_sclk = 1'b1;
        addr = -1;
        if (last) begin
            model_byte(whole, d, addr);
            ev.is_data = d; ev.b = whole; ev.addr = addr; ev.cyc = cyc + 3;
            exp_q.push_back(ev);
        end
        repeat ($urandom_range(2, 4)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, output int addr);
        logic [7:0] sr;
        int dummy;
        sr = b;
        addr = -1;
        for (int i = 7; i >= 1; i--) send_bit(sr[i], d, 1'b0, b, dummy);
        send_bit(sr[0], d, 1'b1, b, addr);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int a;
        send_byte(b, 1'b0, a);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_byte"}, cmd_byte, 0);
        chk({tag, "_byte_err"}, byte_err, 0);
    endtask

    // Compare process: every pulse must match the next expected event in time and content.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && chk_on) begin
            if (wr_en || cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", {30'd0, wr_en, cmd_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("kind_wr_en", wr_en, e.is_data);
                    chk("kind_cmd_valid", cmd_valid, !e.is_data);
                    if (e.is_data) begin
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_data", wr_data, e.b);
                        last_addr = wr_addr;
                        last_data = wr_data;
                    end else begin
                        chk("cmd_byte", cmd_byte, e.b);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missing_pulse", wr_en | cmd_valid, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int a;
        int r;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // First data byte lands at page 0 col 0.
        send_byte(8'hA5, 1'b1, a);
        chk("t1_model_addr", a, 0);
        drain();
        chk("t1_dut_addr", last_addr, 0);
        chk("t1_dut_data", last_data, 8'hA5);

        // Page 3, column 0x25.
        send_cmd(8'hB3); send_cmd(8'h05); send_cmd(8'h12);
        send_byte(8'h3C, 1'b1, a);
        chk("t2_model_addr", a, 10'h1A5);
        drain();
        chk("t2_dut_addr", last_addr, 10'h1A5);
        chk("t2_dut_data", last_data, 8'h3C);

        // Page mode column wrap keeps the page.
        send_cmd(8'hB2); send_cmd(8'h0F); send_cmd(8'h17);
        send_byte(8'h11, 1'b1, a);
        chk("t3_model_addr0", a, 10'h17F);
        send_byte(8'h22, 1'b1, a);
        chk("t3_model_addr1", a, 10'h100);
        drain();
        chk("t3_dut_addr1", last_addr, 10'h100);

        // Horizontal mode wraps column then page.
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'hB7); send_cmd(8'h0F); send_cmd(8'h17);
        send_byte(8'h33, 1'b1, a);
        chk("t4_model_addr0", a, 10'h3FF);
        send_byte(8'h44, 1'b1, a);
        chk("t4_model_addr1", a, 10'h000);
        drain();
        chk("t4_dut_data1", last_data, 8'h44);

        // Reset in the middle of a byte discards it and restores addressing.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0, 8'h00, a);
        oled_sclk = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("midbyte_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'hFF, 1'b1, a);
        chk("t5_model_addr", a, 0);
        drain();
        chk("t5_dut_data", last_data, 8'hFF);

`ifdef OLED_SPI_CS_EN
        // Deselect after 5 bits flags the partial byte; the next byte frames correctly.
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0, 8'h00, a);
        oled_sclk = 1'b0;
        oled_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("cs_byte_err", byte_err, 1);
        oled_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h5A, 1'b1, a);
        drain();
        chk("cs_next_data", last_data, 8'h5A);
`endif

        // Randomized byte stream.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                4: b = 8'h00 | 8'($urandom_range(0, 15));
                5: b = 8'h10 | 8'($urandom_range(0, 15));
                6: b = 8'hB0 | 8'($urandom_range(0, 7));
                7: b = 8'h20;
                8: b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (r <= 3 || r == 9) begin
                send_byte(b, 1'b1, a);
            end else begin
                send_cmd(b);
                if (r == 7 && $urandom_range(0, 1) == 1) send_cmd(8'($urandom_range(0, 3)));
            end
        end
        drain();

`ifdef OLED_SPI_CS_EN
        chk("final_byte_err", byte_err, 1);
`else
        chk("final_byte_err", byte_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
